// File: rtl/sine_dac_pkg.sv
// Shared types and constants for the sine-generator-to-DAC SPI serializer.
package sine_dac_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 10;
    localparam logic [3:0] DEFAULT_CFG_NIBBLE = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        LDAC
    } state_t;

    // DAC word layout: control nibble, 10-bit sample, two don't-care LSBs.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] cfg,
                                                       input logic [DATA_W-1:0] sample);
        return {cfg, sample, 2'b00};
    endfunction

endpackage

// File: rtl/sine_dac_spi_sclk_tick_gen.sv
// Divider producing a one-cycle tick every SCLK_DIV clocks while enabled;
// the count restarts from zero whenever the enable is low.
module sclk_tick_gen #(
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == 8'(SCLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sine_dac_spi.sv
// SPI mode-0 serializer feeding 10-bit sine samples to a DAC, with a one-deep
// pending buffer. Define SINE_DAC_LDAC_EN to add the LDAC latch pulse state.
module sine_dac_spi
    import sine_dac_pkg::*;
#(
    parameter int unsigned SCLK_DIV   = 2,
    parameter logic [3:0]  CFG_NIBBLE = DEFAULT_CFG_NIBBLE
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] iData_sin,
    input  logic              iValid,
    output logic              oReady,
    output logic              oOverrun,
    output logic              oSclk,
    output logic              oCsN,
    output logic              oMosi,
    output logic              oLdacN,
    output logic              oBusy
);

    state_t              state;
    logic [FRAME_W-2:0]  shift_reg;
    logic [3:0]          bit_cnt;
    logic [DATA_W-1:0]   pend_data;
    logic                pend_valid;
    logic                sclk_r;
    logic                csn_r;
    logic                mosi_r;
    logic                busy_r;
    logic                tick;
    logic                accept;
    logic                frame_end;
    logic                start;
    logic [DATA_W-1:0]   start_sample;
    logic [FRAME_W-1:0]  start_frame;

    assign oReady   = (state == IDLE) || !pend_valid;
    assign accept   = iValid && oReady;
    assign oOverrun = iValid && !oReady;

    assign oSclk = sclk_r;
    assign oCsN  = csn_r;
    assign oMosi = mosi_r;
    assign oBusy = busy_r;

    sclk_tick_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_tick_gen (
        .clk (Clk),
        .rst (Reset),
        .en  (state != IDLE),
        .tick(tick)
    );

`ifdef SINE_DAC_LDAC_EN
    logic ldacn_r;
    assign oLdacN    = ldacn_r;
    assign frame_end = tick && (state == LDAC);
`else
    assign oLdacN    = 1'b0;
    assign frame_end = tick && (state == HOLD);
`endif

    // A new frame starts from IDLE, or straight out of the frame tail when a
    // sample is waiting (or arrives on that very cycle, bypassing the buffer).
    assign start        = ((state == IDLE) && accept) || (frame_end && (pend_valid || accept));
    assign start_sample = pend_valid ? pend_data : iData_sin;
    assign start_frame  = build_frame(CFG_NIBBLE, start_sample);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            sclk_r     <= 1'b0;
            csn_r      <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef SINE_DAC_LDAC_EN
            ldacn_r    <= 1'b1;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                        end else begin
                            sclk_r <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                state  <= HOLD;
                                csn_r  <= 1'b1;
                                mosi_r <= 1'b0;
                            end else begin
                                bit_cnt   <= bit_cnt + 4'd1;
                                mosi_r    <= shift_reg[FRAME_W-2];
                                shift_reg <= {shift_reg[FRAME_W-3:0], 1'b0};
                            end
                        end
                    end
                end
`ifdef SINE_DAC_LDAC_EN
                HOLD: begin
                    if (tick) begin
                        state   <= LDAC;
                        ldacn_r <= 1'b0;
                    end
                end
                LDAC: begin
                    if (tick) begin
                        ldacn_r <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase

            if (accept && (state != IDLE)) begin
                pend_data  <= iData_sin;
                pend_valid <= 1'b1;
            end

            // Later assignments here take priority over the state updates above.
            if (start) begin
                state      <= SHIFT;
                csn_r      <= 1'b0;
                busy_r     <= 1'b1;
                sclk_r     <= 1'b0;
                mosi_r     <= start_frame[FRAME_W-1];
                shift_reg  <= start_frame[FRAME_W-2:0];
                bit_cnt    <= '0;
                pend_valid <= 1'b0;
            end else if (frame_end) begin
                state  <= IDLE;
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sine_dac_spi.sv
// Directed self-checking bench for sine_dac_spi at SCLK_DIV=2; expectations
// follow SINE_DAC_LDAC_EN when it is defined for the build.
module tb_sine_dac_spi;

    localparam int DIV = 2;
`ifdef SINE_DAC_LDAC_EN
    localparam int   PERIOD     = 68;
    localparam logic LDAC_IDLE  = 1'b1;
`else
    localparam int   PERIOD     = 66;
    localparam logic LDAC_IDLE  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] data_sin = '0;
    logic       valid = 1'b0;
    logic       ready, overrun, sclk, csn, mosi, ldacn, busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] rx_shift = '0;
    int          rx_bits = 0;
    logic [15:0] rx_frames[$];
    int          rx_nbits[$];
    int          csn_len[$];
    time         csn_fall[$];
    time         last_fall = 0;
    int          ldac_len[$];
    time         ldac_fall = 0;
    int          overrun_cnt = 0;
    int          ldac_bad_cnt = 0;

    sine_dac_spi #(
        .SCLK_DIV  (DIV),
        .CFG_NIBBLE(4'b0011)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .iData_sin(data_sin),
        .iValid   (valid),
        .oReady   (ready),
        .oOverrun (overrun),
        .oSclk    (sclk),
        .oCsN     (csn),
        .oMosi    (mosi),
        .oLdacN   (ldacn),
        .oBusy    (busy)
    );

    always #5 clk = ~clk;

    // Independent SPI receiver and strobe timing monitors
    always @(posedge sclk) begin
        if (!csn) begin
            rx_shift = {rx_shift[14:0], mosi};
            rx_bits++;
        end
    end

    always @(negedge csn) begin
        rx_bits   = 0;
        last_fall = $time;
        csn_fall.push_back($time);
    end

    always @(posedge csn) begin
        if (!rst) begin
            rx_frames.push_back(rx_shift);
            rx_nbits.push_back(rx_bits);
            csn_len.push_back(int'(($time - last_fall) / 10));
        end
    end

    always @(negedge ldacn) ldac_fall = $time;
    always @(posedge ldacn) if (!rst) ldac_len.push_back(int'(($time - ldac_fall) / 10));

    always @(negedge clk) begin
        if (overrun) overrun_cnt++;
`ifndef SINE_DAC_LDAC_EN
        if (ldacn !== 1'b0) ldac_bad_cnt++;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // One-cycle strobe; the accepting edge is the second posedge seen here
    task automatic applyStimulus(input logic [9:0] value);
        @(posedge clk);
        #1;
        data_sin = value;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clearMonitors();
        rx_frames.delete();
        rx_nbits.delete();
        csn_len.delete();
        csn_fall.delete();
        ldac_len.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_csn"},   {31'd0, csn},   32'd1);
        checkOutput({tag, "_sclk"},  {31'd0, sclk},  32'd0);
        checkOutput({tag, "_mosi"},  {31'd0, mosi},  32'd0);
        checkOutput({tag, "_ldacn"}, {31'd0, ldacn}, {31'd0, LDAC_IDLE});
        checkOutput({tag, "_busy"},  {31'd0, busy},  32'd0);
        checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int ov_before;

        // Reset state
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single full-scale sample
        clearMonitors();
        applyStimulus(10'h3FF);
        checkOutput("start_csn", {31'd0, csn}, 32'd0);
        checkOutput("start_mosi", {31'd0, mosi}, 32'd0);
        checkOutput("start_sclk", {31'd0, sclk}, 32'd0);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        waitIdle("single_idle");
        checkOutput("single_nframes", rx_frames.size(), 32'd1);
        checkOutput("single_frame", {16'd0, rx_frames[0]}, 32'h3FFC);
        checkOutput("single_bits", rx_nbits[0], 32'd16);
        checkOutput("single_csn_len", csn_len[0], 32'd64);
`ifdef SINE_DAC_LDAC_EN
        checkOutput("single_nldac", ldac_len.size(), 32'd1);
        checkOutput("single_ldac_len", ldac_len[0], 32'd2);
`endif

        // Zero and mid-scale boundary samples
        clearMonitors();
        applyStimulus(10'h000);
        waitIdle("zero_idle");
        applyStimulus(10'h200);
        waitIdle("mid_idle");
        checkOutput("bound_nframes", rx_frames.size(), 32'd2);
        checkOutput("zero_frame", {16'd0, rx_frames[0]}, 32'h3000);
        checkOutput("mid_frame", {16'd0, rx_frames[1]}, 32'h3800);

        // Back-to-back: second sample parks in the pending buffer
        clearMonitors();
        ov_before = overrun_cnt;
        applyStimulus(10'h2AA);
        repeat (10) @(posedge clk);
        applyStimulus(10'h0F0);
        checkOutput("b2b_ready_low", {31'd0, ready}, 32'd0);
        waitIdle("b2b_idle");
        checkOutput("b2b_nframes", rx_frames.size(), 32'd2);
        checkOutput("b2b_frame0", {16'd0, rx_frames[0]}, 32'h3AA8);
        checkOutput("b2b_frame1", {16'd0, rx_frames[1]}, 32'h33C0);
        checkOutput("b2b_period", int'((csn_fall[1] - csn_fall[0]) / 10), PERIOD);
        checkOutput("b2b_no_overrun", overrun_cnt - ov_before, 32'd0);

        // Overrun: third sample is dropped, second one is sent next
        clearMonitors();
        ov_before = overrun_cnt;
        applyStimulus(10'd1);
        applyStimulus(10'd2);
        applyStimulus(10'd3);
        checkOutput("ovr_count", overrun_cnt - ov_before, 32'd1);
        waitIdle("ovr_idle");
        checkOutput("ovr_nframes", rx_frames.size(), 32'd2);
        checkOutput("ovr_frame0", {16'd0, rx_frames[0]}, 32'h3004);
        checkOutput("ovr_frame1", {16'd0, rx_frames[1]}, 32'h3008);

        // Sample arriving exactly on the frame-completion edge
        clearMonitors();
        ov_before = overrun_cnt;
        applyStimulus(10'h3FF);
        repeat (PERIOD - 2) @(posedge clk);
        applyStimulus(10'h000);
        checkOutput("edge_no_overrun", overrun_cnt - ov_before, 32'd0);
        checkOutput("edge_csn", {31'd0, csn}, 32'd0);
        waitIdle("edge_idle");
        checkOutput("edge_nframes", rx_frames.size(), 32'd2);
        checkOutput("edge_frame1", {16'd0, rx_frames[1]}, 32'h3000);
        checkOutput("edge_period", int'((csn_fall[1] - csn_fall[0]) / 10), PERIOD);

        // Mid-frame reset around bit 7, then a clean frame
        clearMonitors();
        applyStimulus(10'h3FF);
        repeat (4 * DIV * 7 / 2 + 1) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        clearMonitors();
        applyStimulus(10'h155);
        waitIdle("post_rst_idle");
        checkOutput("post_rst_nframes", rx_frames.size(), 32'd1);
        checkOutput("post_rst_frame", {16'd0, rx_frames[0]}, 32'h3554);
        checkOutput("post_rst_csn_len", csn_len[0], 32'd64);
`ifdef SINE_DAC_LDAC_EN
        checkOutput("post_rst_nldac", ldac_len.size(), 32'd1);
`else
        checkOutput("ldacn_const_low", ldac_bad_cnt, 32'd0);
`endif

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
